// File: rtl/fraction_expand_if.sv
// Button/switch inputs and digit-display outputs of the fraction-expand block.
interface fraction_expand_if;
  logic       select;
  logic       add;
  logic       next;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic [3:0] factor;
  logic [1:0] state;

  modport master (output select, add, next, data_in,
                  input  data_out, factor, state);
  modport slave  (input  select, add, next, data_in,
                  output data_out, factor, state);
endinterface

// File: rtl/fraction_expand.sv
// Scales two entered decimal digits up by a common factor; COUNT ramps the
// factor 1..kmax, one step every NUM+1 clocks, then falls back to SETUP.
module fraction_expand #(
  parameter int NUM = 50_000_000
) (
  input logic         clk,
  input logic         rst,
  fraction_expand_if.slave bus
);
  localparam int CW = (NUM < 1) ? 1 : $clog2(NUM + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM);

  typedef enum logic [1:0] {SETUP = 2'd0, SCALE = 2'd1, COUNT = 2'd2} state_t;

  state_t        st, st_n;
  logic [1:0][3:0] bufs, bufs_n;
  logic [3:0]    dout, dout_n, fac, fac_n, kmax, cur, sum_mod;
  logic [4:0]    sum;
  logic [CW-1:0] cnt, cnt_n;
  logic          add_prev, next_prev, add_p, next_p;

  function automatic logic [3:0] prod(input logic [3:0] d, input logic [3:0] f);
    return 4'({4'b0, d} * {4'b0, f});
  endfunction

  assign add_p  = bus.add & ~add_prev;
  assign next_p = bus.next & ~next_prev;
  assign cur    = bufs[bus.select];
  assign sum    = {1'b0, cur} + {1'b0, bus.data_in};

  // Sum is at most 9+15=24, so two conditional subtractions give mod 10.
  always_comb begin
    sum_mod = sum[3:0];
    if (sum >= 5'd20)      sum_mod = 4'(sum - 5'd20);
    else if (sum >= 5'd10) sum_mod = 4'(sum - 5'd10);
  end

  // Products grow with k, so the last k that fits is the largest; zero never limits.
  always_comb begin
    kmax = 4'd1;
    for (int k = 1; k <= 9; k++) begin
      if ((8'(bufs[0]) * 8'(k) <= 8'd9) && (8'(bufs[1]) * 8'(k) <= 8'd9))
        kmax = 4'(k);
    end
  end

  always_comb begin
    st_n   = st;
    bufs_n = bufs;
    dout_n = dout;
    fac_n  = fac;
    cnt_n  = cnt;
    case (st)
      SETUP: begin
        fac_n  = 4'd1;
        dout_n = cur;
        if (add_p) begin
          bufs_n[bus.select] = sum_mod;
          dout_n             = sum_mod;
        end
        if (next_p) st_n = SCALE;
      end
      SCALE: begin
        fac_n  = kmax;
        dout_n = prod(cur, kmax);
        if (next_p) begin
          st_n  = COUNT;
          fac_n = 4'd1;
          cnt_n = '0;
        end
      end
      COUNT: begin
        dout_n = prod(cur, fac);
        cnt_n  = cnt + CW'(1);
        // An abort from the button wins over a same-cycle factor step.
        if (next_p) begin
          st_n   = SETUP;
          fac_n  = 4'd1;
          dout_n = cur;
          cnt_n  = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_n = '0;
          if (fac == kmax) begin
            st_n   = SETUP;
            fac_n  = 4'd1;
            dout_n = cur;
          end else begin
            fac_n = fac + 4'd1;
          end
        end
      end
      default: begin
        st_n   = SETUP;
        fac_n  = 4'd1;
        dout_n = cur;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= SETUP;
      bufs      <= '0;
      dout      <= '0;
      fac       <= 4'd1;
      cnt       <= '0;
      add_prev  <= 1'b0;
      next_prev <= 1'b0;
    end else begin
      st        <= st_n;
      bufs      <= bufs_n;
      dout      <= dout_n;
      fac       <= fac_n;
      cnt       <= cnt_n;
      add_prev  <= bus.add;
      next_prev <= bus.next;
    end
  end

  assign bus.data_out = dout;
  assign bus.factor   = fac;
  assign bus.state    = st;
endmodule

// File: tb/tb_fraction_expand.sv
// Scoreboard bench: a cycle model predicts outputs per edge, a monitor compares on negedge.
module tb_fraction_expand;
  localparam int NUM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fraction_expand_if bus();

  fraction_expand #(.NUM(NUM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dout;
    int fac;
    int st;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  int mb[2];
  int mdout, mfac, mst, mcnt, mpadd, mpnext;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int kref();
    int a;
    int b;
    a = (mb[0] == 0) ? 9 : 9 / mb[0];
    b = (mb[1] == 0) ? 9 : 9 / mb[1];
    return (a < b) ? a : b;
  endfunction

  // Reference model: spec rules in plain integer arithmetic.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb[0] = 0; mb[1] = 0;
      mdout = 0; mfac = 1; mst = 0; mcnt = 0; mpadd = 0; mpnext = 0;
      q.delete();
      q.push_back('{0, 1, 0});
    end else begin
      int ap, np, k, s;
      ap = (bus.add && mpadd == 0) ? 1 : 0;
      np = (bus.next && mpnext == 0) ? 1 : 0;
      s  = int'(bus.select);
      k  = kref();
      case (mst)
        0: begin
          if (ap == 1) mb[s] = (mb[s] + int'(bus.data_in)) % 10;
          mdout = mb[s];
          mfac  = 1;
          if (np == 1) mst = 1;
        end
        1: begin
          mfac  = k;
          mdout = mb[s] * k;
          if (np == 1) begin mst = 2; mfac = 1; mcnt = 0; end
        end
        default: begin
          mdout = mb[s] * mfac;
          if (np == 1) begin
            mst = 0; mfac = 1; mdout = mb[s]; mcnt = 0;
          end else if (mcnt == NUM) begin
            mcnt = 0;
            if (mfac == k) begin mst = 0; mfac = 1; mdout = mb[s]; end
            else mfac = mfac + 1;
          end else begin
            mcnt = mcnt + 1;
          end
        end
      endcase
      mpadd  = bus.add ? 1 : 0;
      mpnext = bus.next ? 1 : 0;
      q.push_back('{mdout, mfac, mst});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_data_out", int'(bus.data_out), e.dout);
      chk("sb_factor",   int'(bus.factor),   e.fac);
      chk("sb_state",    int'(bus.state),    e.st);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_add(input int d);
    bus.add = 1'b1; bus.data_in = 4'(d);
    tick(1);
    bus.add = 1'b0;
    tick(1);
  endtask

  task automatic press_next();
    bus.next = 1'b1;
    tick(1);
    bus.next = 1'b0;
    tick(1);
  endtask

  task automatic chk_out(input string name, input int d, input int f, input int s);
    chk({name, "_data_out"}, int'(bus.data_out), d);
    chk({name, "_factor"},   int'(bus.factor),   f);
    chk({name, "_state"},    int'(bus.state),    s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus.select = 1'b0; bus.add = 1'b0; bus.next = 1'b0; bus.data_in = 4'd0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk_out("reset", 0, 1, 0);

    // Entry and wrap
    press_add(7);
    chk_out("add7", 7, 1, 0);
    press_add(5);
    chk_out("wrap", 2, 1, 0);
    bus.select = 1'b1; tick(1);
    chk_out("sel1", 0, 1, 0);
    press_add(3);
    chk_out("buf1", 3, 1, 0);
    bus.select = 1'b0; tick(1);

    // SCALE
    press_next();
    chk_out("scale", 6, 3, 1);
    bus.select = 1'b1; tick(1);
    chk_out("scale_sel1", 9, 3, 1);
    bus.select = 1'b0; tick(1);
    press_add(4);
    chk_out("scale_add_ignored", 6, 3, 1);

    // COUNT ramp
    press_next();
    tick(4);
    chk_out("ramp_mid", 4, 2, 2);
    tick(7);
    chk_out("ramp_end", 2, 1, 0);

    // Abort on the counter tick, then a held next
    press_next();
    press_next();
    tick(2);
    bus.next = 1'b1;
    tick(1);
    chk_out("abort", 2, 1, 0);
    tick(3);
    chk("held_next_state", int'(bus.state), 0);
    bus.next = 1'b0;
    tick(1);
    bus.select = 1'b1; tick(1);
    chk_out("buf_kept", 3, 1, 0);

    // Zero operands
    press_add(7);
    bus.select = 1'b0;
    press_add(8);
    chk_out("zeros", 0, 1, 0);
    press_next();
    chk_out("zero_scale", 0, 9, 1);
    press_next();
    tick(20);
    chk_out("zero_ramp", 0, 6, 2);
    tick(15);
    chk_out("zero_done", 0, 1, 0);

    // Async reset mid-COUNT
    press_add(4);
    press_next();
    press_next();
    tick(1);
    #1 rst = 1'b1;
    #1 chk_out("async_rst", 0, 1, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk_out("post_rst", 0, 1, 0);
    press_add(6);
    chk_out("post_rst_add", 6, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.select  = 1'($urandom_range(0, 1));
      bus.data_in = 4'($urandom_range(0, 15));
      bus.add     = ($urandom_range(0, 3) == 0);
      bus.next    = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    rst = 1'b0; bus.add = 1'b0; bus.next = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fraction_expand.md
Name: fraction_expand

Overview:
- Board-level digit block, the inverse of the team's fraction-reduce block.
- Two user-entered decimal digits (numerator/denominator) are scaled UP by a common factor instead of being reduced by their GCD.
- Driven by the same push-button/switch interface (add, next, select, 4-bit data_in); drives the same 4-bit digit display path.
- The COUNT phase ramps the factor upward, one step per NUM+1 clocks, until either digit would exceed 9.

Parameters:
NUM, 50_000_000, clock cycles per factor step minus one (factor advances every NUM+1 cycles); benches use NUM=3

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
select  input  1  chooses digit buffer 0 or 1 for edit/display
add  input  1  level button; rising edge adds data_in to selected buffer
next  input  1  level button; rising edge advances state
data_in  input  4  addend, 0..15 accepted
data_out  output  4  displayed digit, registered
factor  output  4  current multiplier, registered
state  output  2  current FSM state (SETUP=0, SCALE=1, COUNT=2)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: buf[0]=buf[1]=0, data_out=0, factor=1, state=SETUP, cycle counter=0, edge-detect history flops=0.
- Edge detect: one registered history flop per button. Pulse = in & ~in_prev. The action occurs at the first rising clk where in=1 and in_prev=0. A held button produces exactly one pulse.
- kmax: combinational function of buf[0] and buf[1]. It is the largest k in 1..9 with buf[0]*k<=9 and buf[1]*k<=9. A zero digit never limits, so both zero gives kmax=9. Products are computed at 8 bits; all displayed products are <=9.
- SETUP:
  - add pulse: buf[select] <= (buf[select]+data_in) mod 10, with the sum computed at 5 bits.
  - data_out <= post-update value of buf[select].
  - factor <= 1.
  - next pulse -> SCALE.
  - add and next in the same cycle: both take effect (buffer updated, then transition).
- SCALE:
  - factor <= kmax.
  - data_out <= buf[select]*kmax, updated every cycle, so it tracks select changes.
  - add ignored.
  - next pulse -> COUNT, with factor <= 1 and counter <= 0.
- COUNT:
  - data_out <= buf[select]*factor every cycle.
  - Counter increments each cycle. When counter==NUM: counter <= 0, and
    - if factor==kmax: -> SETUP, factor <= 1, data_out <= buf[select];
    - otherwise factor <= factor+1.
  - next pulse -> SETUP immediately (factor <= 1, data_out <= buf[select], counter <= 0). This takes priority over a same-cycle counter tick.
  - add ignored.
- Buffers change only in SETUP.
- Unused state encoding 3 -> SETUP on next clock; outputs as in SETUP.
- Reset mid-operation: all registers return to reset values asynchronously; nothing is retained.
- Latency: every output is registered and reflects inputs sampled at the previous clk edge.

Test Plan:
- Entry and wrap: rst, select=0, add with data_in=7 -> data_out=7. Add again with data_in=5 -> buf[0]=2, data_out=2. Select=1 -> data_out=0 next cycle.
- SCALE: buf0=2, buf1=3, next -> state=1, factor=3, data_out=6 (select=0). Select=1 -> data_out=9.
- COUNT ramp (NUM=3, buf0=2, buf1=3, select=0): next -> data_out 2,4,6 each held 4 cycles, factor 1,2,3. After the third window: state=0, data_out=2, factor=1.
- Zero operands: buf0=0, buf1=0, next -> factor=9, data_out=0. In COUNT, factor steps 1..9 before returning to SETUP.
- Abort and priority: in COUNT, pulse next on the cycle counter==NUM -> state=0, factor=1, buffers unchanged. A held next generates only one transition. Add pulses in SCALE/COUNT leave buffers unchanged.
- Async reset: assert rst mid-COUNT between clock edges -> outputs 0/1/0 (data_out/factor/state) immediately, buffers 0. Deassert -> SETUP behaviour resumes.
